ccd_line_capture: RTL and testbench
===================================

Name: ccd_line_capture

Overview:
Downstream consumer of the CCD/ADC timing stage. It resynchronises the slow pixel strobe (pix_clk), the line-valid flag and the 16-bit pixel word into the clk_80M domain. It frames the valid pixels into lines with first and last markers and buffers them in a small FIFO. The FIFO output is a valid/ready stream toward the line store / USB packer.

Parameters:
PIX_W, 16, pixel word width
FIFO_DEPTH, 8, output FIFO entries (power of 2)
MAX_PIX, 2088, maximum pixels accepted per line; extras are discarded
LINE_W, 16, width of line counter

Ports:
clk_80M  in  1  system clock, 80 MHz
rst  in  1  synchronous, active-high reset
en  in  1  capture enable; low = synchronous clear (flags kept)
pix_clk  in  1  pixel strobe from timing stage; async to clk_80M phase, period 40 clk
pix_out_valid  in  1  line-valid flag, changes on falling edge of CCD phase clock
pix_data  in  PIX_W  pixel word; stable for ≥20 clk around pix_clk rise
m_data  out  PIX_W  output pixel
m_sof  out  1  first pixel of line
m_last  out  1  last pixel of line
m_valid  out  1  output word available
m_ready  in  1  downstream accepts
line_cnt  out  LINE_W  completed lines since reset/en rise, wraps
last_line_len  out  12  pixel count of most recently completed line
overflow  out  1  sticky: FIFO-full drop occurred
len_err  out  1  sticky: line exceeded MAX_PIX

Behaviour:
- Clocking and reset: one clock, clk_80M. Reset is synchronous and active-high (rst). On rst, all state and outputs are 0, including the FIFO (empty), the flags, line_cnt and last_line_len.
- Synchroniser: pix_clk and pix_out_valid each pass through 2 flops, plus a third flop for edge detection.
  - pe = rising edge of synced pix_clk.
  - vf = falling edge of synced valid.
- Capture: on pe with synced valid = 1, pix_data is registered directly. It is quasi-static, so no multi-bit synchroniser is needed.
  - If pix_cnt ≥ MAX_PIX: discard the word and set len_err.
  - Otherwise: pix_cnt++.
- Hold register (one pixel deep): it delays each pixel so the last pixel can be tagged.
  - On capture with hold occupied: push the held word with last=0, then load the new word.
  - On capture with hold empty: load only, no push.
  - sof is set on the first capture after reset, after en rises, or after a vf.
- Line end (vf):
  - If hold is occupied: push the held word with last=1 and clear hold.
  - last_line_len <= pix_cnt; line_cnt++ (wraps); pix_cnt <= 0.
  - A vf with zero pixels captured still updates last_line_len to 0 and increments line_cnt.
- Simultaneous events:
  - Capture needs valid=1 and vf needs valid=0, so they never coincide and at most one push occurs per cycle.
  - A pe in the same cycle as vf is ignored.
- FIFO:
  - A push while full is dropped and sets overflow; the hold register still advances.
  - Pop happens when m_valid & m_ready.
  - Push and pop in the same cycle while full: the pop frees space first and the push succeeds.
  - m_valid = !empty. m_data, m_sof and m_last come from the head entry (first-word fall-through); they are stable while m_valid & !m_ready.
- Latency: a pixel reaches the FIFO head 1 clk after the next pixel's capture, or 1 clk after vf. That is roughly 40–43 clk after its own pix_clk rise.
- en low (sampled each clk):
  - Clears the synchroniser history, hold register, pix_cnt, line_cnt, last_line_len and FIFO.
  - overflow and len_err are kept and are cleared only by rst.
  - On en rise, pixels are captured only from the first pe. A line already in progress is framed with sof on its first captured pixel.
- Reset mid-line: everything clears. The partial line is lost and no last is emitted.

Decomposition:
- Package ccd_pkg:
  - PIX_W and MAX_PIX constants.
  - typedef struct packed pix_word_t {logic sof; logic last; logic [PIX_W-1:0] data;}.
- One sub-module: ccd_sync_fifo.
  - Parameterised on depth and pix_word_t.
  - Synchronous rst, first-word fall-through.
  - Outputs full/empty; push and pop may occur in the same cycle.

Test Plan:
- Line of 5 pixels (0x0011..0x0015, pix_clk period 40 clk, valid high across them), m_ready=1 -> 5 words in order; sof on 0x0011 only, last on 0x0015 only; line_cnt=1, last_line_len=5.
- Full 2088-pixel line, then a 2090-pixel line -> first line: last_line_len=2088, len_err=0. Second line: only 2088 words emitted, len_err=1, last on word 2088.
- m_ready=0 for a 12-pixel line -> first 8 words held; subsequent pushes dropped and overflow=1. After m_ready=1, exactly 8 words drain, unchanged, with no last.
- Valid falls with no captured pixel -> no output word; line_cnt increments; last_line_len=0.
- en low for 3 clk mid-line (after 4 pixels) -> FIFO empties and counters clear. After en rises, the next captured pixel carries sof=1; overflow and len_err are unchanged.
- rst asserted during an active line -> all outputs 0 next clk, including the sticky flags. The next line is framed normally with sof, last and a correct last_line_len.

Source files
------------

// File: rtl/ccd_pkg.sv
// ---------------------------------------------------------------------------
// ccd_pkg
// Shared constants and the FIFO word layout used by the CCD line-capture
// block. The capture path and the output FIFO both carry pix_word_t, so the
// data width and the framing markers travel together.
// ---------------------------------------------------------------------------
package ccd_pkg;

  localparam int PIX_W   = 16;    // pixel word width
  localparam int MAX_PIX = 2088;  // default cap on pixels accepted per line
  localparam int LEN_W   = 12;    // width of per-line pixel counters

  // One framed pixel: sof marks the first word of a line, last the final one.
  typedef struct packed {
    logic             sof;
    logic             last;
    logic [PIX_W-1:0] data;
  } pix_word_t;

endpackage

// File: rtl/ccd_sync_fifo.sv
// ---------------------------------------------------------------------------
// ccd_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// head_o whenever empty_o is low. A push while full succeeds only if a pop
// happens in the same cycle; otherwise it is ignored (the caller flags it).
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (empties the FIFO)
//   clr_i        synchronous clear, same effect as reset
//   push_i       write push_data_i at the tail
//   push_data_i  word to write
//   pop_i        remove the head entry (ignored when empty)
//   head_o       current head entry (undefined content while empty)
//   full_o       all DEPTH entries occupied
//   empty_o      no entries
// ---------------------------------------------------------------------------
module ccd_sync_fifo
  import ccd_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter type word_t = pix_word_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clr_i,
  input  logic  push_i,
  input  word_t push_data_i,
  input  logic  pop_i,
  output word_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  word_t       mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers define which entries
  // are meaningful, and the top masks the head while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/ccd_line_capture.sv
// ---------------------------------------------------------------------------
// ccd_line_capture
// Resynchronises the slow pixel strobe and line-valid flag from the CCD/ADC
// timing stage into clk_80M, captures pixel words, frames them into lines
// (sof on the first pixel, last on the final one) and queues them in a small
// FIFO presented as a valid/ready stream.
//
// Ports:
//   clk_80M        system clock
//   rst            synchronous active-high reset, clears everything
//   en             capture enable; low clears datapath and counters, keeps flags
//   pix_clk        pixel strobe (asynchronous to clk_80M)
//   pix_out_valid  line-valid flag (asynchronous to clk_80M)
//   pix_data       pixel word, quasi-static around the pix_clk rise
//   m_data/m_sof/m_last/m_valid/m_ready   output stream (FWFT head)
//   line_cnt       completed lines since reset / en rise (wraps)
//   last_line_len  pixel count of the most recently completed line
//   overflow       sticky: a word was dropped because the FIFO was full
//   len_err        sticky: a line carried more than MAX_PIX pixels
// ---------------------------------------------------------------------------
module ccd_line_capture
  import ccd_pkg::PIX_W, ccd_pkg::LEN_W, ccd_pkg::pix_word_t;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_PIX    = ccd_pkg::MAX_PIX,
  parameter int LINE_W     = 16
) (
  input  logic              clk_80M,
  input  logic              rst,
  input  logic              en,
  input  logic              pix_clk,
  input  logic              pix_out_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_sof,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LINE_W-1:0] line_cnt,
  output logic [LEN_W-1:0]  last_line_len,
  output logic              overflow,
  output logic              len_err
);

  localparam logic [LEN_W-1:0] MAX_PIX_C = LEN_W'(MAX_PIX);

  // Synchroniser chains: [0] first flop, [1] synced value, [2] edge history.
  logic [2:0]        pclk_sync_q, pclk_sync_d;
  logic [2:0]        val_sync_q,  val_sync_d;
  // Fills with ones after a clear; edges count only once [2] holds real history,
  // so a strobe already high at en rise is not mistaken for a rising edge.
  logic [2:0]        hist_q,      hist_d;

  pix_word_t         hold_q,      hold_d;
  logic              hold_vld_q,  hold_vld_d;
  logic              line_open_q, line_open_d;   // low => next capture gets sof
  logic [LEN_W-1:0]  pix_cnt_q,   pix_cnt_d;
  logic [LEN_W-1:0]  last_len_q,  last_len_d;
  logic [LINE_W-1:0] line_cnt_q,  line_cnt_d;
  logic              overflow_q,  overflow_d;
  logic              len_err_q,   len_err_d;

  logic              pe, vf, cap;
  logic              push;
  pix_word_t         push_word;
  logic              pop, full, empty;
  pix_word_t         head;

  assign pe  = hist_q[2] &  pclk_sync_q[1] & ~pclk_sync_q[2];
  assign vf  = hist_q[2] & ~val_sync_q[1]  &  val_sync_q[2];
  // Capture needs synced valid high, so it can never coincide with vf.
  assign cap = pe & val_sync_q[1];
  assign pop = m_ready & ~empty;

  always_comb begin
    pclk_sync_d = {pclk_sync_q[1:0], pix_clk};
    val_sync_d  = {val_sync_q[1:0], pix_out_valid};
    hist_d      = {hist_q[1:0], 1'b1};
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    line_open_d = line_open_q;
    pix_cnt_d   = pix_cnt_q;
    last_len_d  = last_len_q;
    line_cnt_d  = line_cnt_q;
    overflow_d  = overflow_q;
    len_err_d   = len_err_q;
    push        = 1'b0;
    push_word   = hold_q;

    if (cap) begin
      if (pix_cnt_q >= MAX_PIX_C) begin
        len_err_d = 1'b1;
      end else begin
        // The held pixel is not the last one, since another pixel followed.
        push        = hold_vld_q;
        hold_d.sof  = ~line_open_q;
        hold_d.last = 1'b0;
        hold_d.data = pix_data;
        hold_vld_d  = 1'b1;
        line_open_d = 1'b1;
        pix_cnt_d   = pix_cnt_q + 1'b1;
      end
    end else if (vf) begin
      push           = hold_vld_q;
      push_word.last = 1'b1;
      hold_vld_d     = 1'b0;
      line_open_d    = 1'b0;
      last_len_d     = pix_cnt_q;
      line_cnt_d     = line_cnt_q + 1'b1;
      pix_cnt_d      = '0;
    end

    if (!en) begin
      pclk_sync_d = '0;
      val_sync_d  = '0;
      hist_d      = '0;
      hold_d      = '0;
      hold_vld_d  = 1'b0;
      line_open_d = 1'b0;
      pix_cnt_d   = '0;
      last_len_d  = '0;
      line_cnt_d  = '0;
      push        = 1'b0;
    end

    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_80M) begin
    if (rst) begin
      pclk_sync_q <= '0;
      val_sync_q  <= '0;
      hist_q      <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      line_open_q <= 1'b0;
      pix_cnt_q   <= '0;
      last_len_q  <= '0;
      line_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      pclk_sync_q <= pclk_sync_d;
      val_sync_q  <= val_sync_d;
      hist_q      <= hist_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      line_open_q <= line_open_d;
      pix_cnt_q   <= pix_cnt_d;
      last_len_q  <= last_len_d;
      line_cnt_q  <= line_cnt_d;
      overflow_q  <= overflow_d;
      len_err_q   <= len_err_d;
    end
  end

  ccd_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .word_t (pix_word_t)
  ) u_fifo (
    .clk_i       (clk_80M),
    .rst_i       (rst),
    .clr_i       (~en),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign m_valid       = ~empty;
  assign m_data        = empty ? '0 : head.data;
  assign m_sof         = ~empty & head.sof;
  assign m_last        = ~empty & head.last;
  assign line_cnt      = line_cnt_q;
  assign last_line_len = last_len_q;
  assign overflow      = overflow_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_ccd_line_capture.sv
// ---------------------------------------------------------------------------
// tb_ccd_line_capture
// Scenario tasks drive pixel lines; expected words are queued as stimulus is
// issued and a monitor compares every word the DUT hands over.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccd_line_capture;

  logic        clk_80M = 1'b0;
  logic        rst;
  logic        en;
  logic        pix_clk;
  logic        pix_out_valid;
  logic [15:0] pix_data;
  logic [15:0] m_data;
  logic        m_sof;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] line_cnt;
  logic [11:0] last_line_len;
  logic        overflow;
  logic        len_err;

  int compared   = 0;
  int mismatched = 0;

  // Expected words: {sof, last, data}
  logic [17:0] exp_q[$];

  always #5 clk_80M = ~clk_80M;

  ccd_line_capture dut (
    .clk_80M       (clk_80M),
    .rst           (rst),
    .en            (en),
    .pix_clk       (pix_clk),
    .pix_out_valid (pix_out_valid),
    .pix_data      (pix_data),
    .m_data        (m_data),
    .m_sof         (m_sof),
    .m_last        (m_last),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .line_cnt      (line_cnt),
    .last_line_len (last_line_len),
    .overflow      (overflow),
    .len_err       (len_err)
  );

  // Monitor: a handshake completes at the next posedge when valid & ready.
  always begin
    logic [17:0] e;
    @(negedge clk_80M);
    #1;
    if (m_valid && m_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_word: got sof=%b last=%b data=%h, required no word",
                 m_sof, m_last, m_data);
      end else begin
        e = exp_q.pop_front();
        if ({m_sof, m_last, m_data} !== e) begin
          mismatched++;
          $display("FAIL word: got sof=%b last=%b data=%h, required sof=%b last=%b data=%h",
                   m_sof, m_last, m_data, e[17], e[16], e[15:0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_80M);
  endtask

  task automatic exp_push(input logic sof, input logic last, input logic [15:0] d);
    exp_q.push_back({sof, last, d});
  endtask

  // Queue the expected words of a line: n_exp words from base, optional last.
  task automatic exp_line(input int n_exp, input logic [15:0] base, input logic with_last);
    for (int i = 0; i < n_exp; i++)
      exp_push(i == 0, with_last && (i == n_exp - 1), base + 16'(i));
  endtask

  task automatic drive_pixel(input logic [15:0] d, input int lo, input int hi);
    pix_data = d;
    cyc(lo);
    pix_clk = 1'b1;
    cyc(hi);
    pix_clk = 1'b0;
  endtask

  task automatic send_pixels(input int n, input logic [15:0] base, input int lo, input int hi);
    for (int i = 0; i < n; i++) drive_pixel(base + 16'(i), lo, hi);
  endtask

  task automatic send_line(input int n, input logic [15:0] base, input int lo, input int hi);
    pix_out_valid = 1'b1;
    cyc(4);
    send_pixels(n, base, lo, hi);
    cyc(4);
    pix_out_valid = 1'b0;
    cyc(8);
  endtask

  // Waits (bounded) until every expected word has been consumed.
  task automatic wait_empty(input int budget, output int left);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    left = exp_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; pix_clk = 1'b0; pix_out_valid = 1'b0;
    pix_data = '0; m_ready = 1'b0;
    cyc(3);
    compared++;
    if ({m_valid, m_sof, m_last, m_data} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_stream: got valid=%b sof=%b last=%b data=%h, required all 0",
               m_valid, m_sof, m_last, m_data);
    end
    compared++;
    if ({line_cnt, last_line_len, overflow, len_err} !== 30'd0) begin
      mismatched++;
      $display("FAIL reset_status: got line_cnt=%0d len=%0d ovf=%b len_err=%b, required all 0",
               line_cnt, last_line_len, overflow, len_err);
    end
    rst = 1'b0;
    cyc(4);
  endtask

  task automatic test_basic_line;
    int left;
    m_ready = 1'b1;
    exp_line(5, 16'h0011, 1'b1);
    send_line(5, 16'h0011, 20, 20);
    wait_empty(100, left);
    compared++;
    if (left != 0) begin
      mismatched++;
      $display("FAIL basic_drain: got %0d words missing, required 0", left);
    end
    compared++;
    if (line_cnt !== 16'd1 || last_line_len !== 12'd5) begin
      mismatched++;
      $display("FAIL basic_counts: got line_cnt=%0d len=%0d, required 1 / 5",
               line_cnt, last_line_len);
    end
  endtask

  task automatic test_empty_line;
    pix_out_valid = 1'b1;
    cyc(10);
    pix_out_valid = 1'b0;
    cyc(12);
    compared++;
    if (line_cnt !== 16'd2 || last_line_len !== 12'd0 || m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL empty_line: got line_cnt=%0d len=%0d valid=%b, required 2 / 0 / 0",
               line_cnt, last_line_len, m_valid);
    end
  endtask

  task automatic test_max_len;
    int left;
    exp_line(2088, 16'h1000, 1'b1);
    send_line(2088, 16'h1000, 3, 5);
    wait_empty(100, left);
    compared++;
    if (left != 0) begin
      mismatched++;
      $display("FAIL max_drain: got %0d words missing, required 0", left);
    end
    compared++;
    if (last_line_len !== 12'd2088 || len_err !== 1'b0 || line_cnt !== 16'd3) begin
      mismatched++;
      $display("FAIL max_line: got len=%0d len_err=%b line_cnt=%0d, required 2088 / 0 / 3",
               last_line_len, len_err, line_cnt);
    end
    // Two pixels beyond the cap are discarded; the 2088th word carries last.
    exp_line(2088, 16'h2000, 1'b1);
    send_line(2090, 16'h2000, 3, 5);
    wait_empty(100, left);
    compared++;
    if (left != 0) begin
      mismatched++;
      $display("FAIL over_max_drain: got %0d words missing, required 0", left);
    end
    compared++;
    if (last_line_len !== 12'd2088 || len_err !== 1'b1 || line_cnt !== 16'd4) begin
      mismatched++;
      $display("FAIL over_max_line: got len=%0d len_err=%b line_cnt=%0d, required 2088 / 1 / 4",
               last_line_len, len_err, line_cnt);
    end
  endtask

  task automatic test_overflow;
    int left;
    m_ready = 1'b0;
    exp_line(8, 16'h3000, 1'b0);
    send_line(12, 16'h3000, 20, 20);
    compared++;
    if (overflow !== 1'b1 || m_valid !== 1'b1 || m_data !== 16'h3000 || m_sof !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_hold: got ovf=%b valid=%b data=%h sof=%b, required 1 / 1 / 3000 / 1",
               overflow, m_valid, m_data, m_sof);
    end
    m_ready = 1'b1;
    wait_empty(50, left);
    cyc(10);
    compared++;
    if (left != 0 || m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_drain: got %0d missing, valid=%b, required 0 / 0", left, m_valid);
    end
    compared++;
    if (line_cnt !== 16'd5 || last_line_len !== 12'd12) begin
      mismatched++;
      $display("FAIL ovf_counts: got line_cnt=%0d len=%0d, required 5 / 12",
               line_cnt, last_line_len);
    end
  endtask

  task automatic test_en_low;
    int left;
    m_ready = 1'b1;
    // Fourth pixel is still in the hold register when en drops, so it is lost.
    exp_line(3, 16'h4000, 1'b0);
    pix_out_valid = 1'b1;
    cyc(4);
    send_pixels(4, 16'h4000, 20, 20);
    cyc(2);
    en = 1'b0;
    cyc(3);
    compared++;
    if (m_valid !== 1'b0 || line_cnt !== 16'd0 || last_line_len !== 12'd0 ||
        overflow !== 1'b1 || len_err !== 1'b1) begin
      mismatched++;
      $display("FAIL en_low_clear: got valid=%b line_cnt=%0d len=%0d ovf=%b len_err=%b, required 0/0/0/1/1",
               m_valid, line_cnt, last_line_len, overflow, len_err);
    end
    en = 1'b1;
    exp_line(3, 16'h4010, 1'b1);
    cyc(4);
    send_pixels(3, 16'h4010, 20, 20);
    cyc(4);
    pix_out_valid = 1'b0;
    cyc(8);
    wait_empty(100, left);
    compared++;
    if (left != 0) begin
      mismatched++;
      $display("FAIL en_drain: got %0d words missing, required 0", left);
    end
    compared++;
    if (line_cnt !== 16'd1 || last_line_len !== 12'd3 || overflow !== 1'b1 || len_err !== 1'b1) begin
      mismatched++;
      $display("FAIL en_counts: got line_cnt=%0d len=%0d ovf=%b len_err=%b, required 1/3/1/1",
               line_cnt, last_line_len, overflow, len_err);
    end
  endtask

  task automatic test_reset_midline;
    int left;
    m_ready = 1'b1;
    exp_line(2, 16'h5000, 1'b0);
    pix_out_valid = 1'b1;
    cyc(4);
    send_pixels(3, 16'h5000, 20, 20);
    cyc(4);
    rst = 1'b1;
    pix_out_valid = 1'b0;
    cyc(1);
    compared++;
    if ({m_valid, m_sof, m_last, m_data, line_cnt, last_line_len, overflow, len_err} !== 49'd0) begin
      mismatched++;
      $display("FAIL midline_reset: got valid=%b data=%h line_cnt=%0d len=%0d ovf=%b len_err=%b, required all 0",
               m_valid, m_data, line_cnt, last_line_len, overflow, len_err);
    end
    wait_empty(1, left);
    compared++;
    if (left != 0) begin
      mismatched++;
      $display("FAIL midline_words: got %0d words missing, required 0", left);
    end
    cyc(2);
    rst = 1'b0;
    cyc(4);
    exp_line(4, 16'h5100, 1'b1);
    send_line(4, 16'h5100, 20, 20);
    wait_empty(100, left);
    compared++;
    if (left != 0 || line_cnt !== 16'd1 || last_line_len !== 12'd4) begin
      mismatched++;
      $display("FAIL post_reset_line: got missing=%0d line_cnt=%0d len=%0d, required 0 / 1 / 4",
               left, line_cnt, last_line_len);
    end
  endtask

  initial begin
    test_reset;
    test_basic_line;
    test_empty_line;
    test_max_len;
    test_overflow;
    test_en_low;
    test_reset_midline;
    cyc(20);
    compared++;
    if (m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL final_idle: got valid=%b, required 0", m_valid);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
